// File: rtl/pdm2pcm_pkg.sv
// Shared types and helpers for the PDM2PCM microphone front end.
package pdm2pcm_pkg;

  localparam int unsigned DIV_W = 8;

  localparam logic PDM_CHANNEL_LEFT  = 1'b0;
  localparam logic PDM_CHANNEL_RIGHT = 1'b1;

  typedef enum logic [1:0] {MIC_IDLE, MIC_WAKEUP, MIC_RUN} pdm_mic_state_t;

  typedef struct packed {
    logic pdm;
    logic valid;
    logic channel;
  } pdm_sample_t;

  // Raises the divisor to the minimum that still lets the synchronizer settle per half-period.
  function automatic logic [DIV_W-1:0] clamp_divisor(input logic [DIV_W-1:0] d,
                                                     input int unsigned min_d);
    if (d < DIV_W'(min_d)) return DIV_W'(min_d);
    return d;
  endfunction

endpackage

// File: rtl/pdm_clock_divider.sv
// PDM clock generator: half-period counter, divisor latch/clamp, toggle and rising strobes.
module pdm_clock_divider
  import pdm2pcm_pkg::*;
#(
  parameter int unsigned MIN_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             active,
  input  logic             load,
  input  logic [DIV_W-1:0] divisor,
  output logic             pdm_clk,
  output logic             toggle_c,
  output logic             rising_c
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;

  assign toggle_c = active && (cnt_q == div_q);
  assign rising_c = toggle_c && !pdm_clk;

  // Divisor is re-latched only at half-period boundaries so a change never truncates one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      div_q   <= DIV_W'(MIN_DIV);
      pdm_clk <= 1'b0;
    end else begin
      if (load) div_q <= clamp_divisor(divisor, MIN_DIV);
      if (!active) begin
        cnt_q   <= '0;
        pdm_clk <= 1'b0;
      end else if (toggle_c) begin
        cnt_q   <= '0;
        pdm_clk <= ~pdm_clk;
        div_q   <= clamp_divisor(divisor, MIN_DIV);
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/pdm2pcm_mic_interface.sv
// PDM microphone interface: mic clock, data synchronizer, wake-up masking and sample strobes.
// Define PDM2PCM_STEREO_EN to emit both edges (L,R,L,R...) instead of the channel_sel_i edge only.
module pdm2pcm_mic_interface
  import pdm2pcm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned WAKEUP_PERIODS = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clk_en_i,
  input  logic [DIV_W-1:0] clock_divisor_i,
  input  logic             channel_sel_i,
  output logic             pdm_clk_o,
  input  logic             pdm_data_i,
  output logic             pdm_o,
  output logic             valid_o,
  output logic             channel_o
);

  localparam int unsigned WAKE_W = $clog2(WAKEUP_PERIODS + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   data_sync;
  pdm_mic_state_t         state_q;
  logic [WAKE_W-1:0]      wake_q;
  pdm_sample_t            out_q;
  logic                   active;
  logic                   load;
  logic                   toggle_c;
  logic                   rising_c;
  logic                   edge_ch;
  logic                   take;

  assign active    = clk_en_i && (state_q != MIC_IDLE);
  assign load      = clk_en_i && (state_q == MIC_IDLE);
  assign data_sync = sync_q[SYNC_STAGES-1];
  assign edge_ch   = pdm_clk_o ? PDM_CHANNEL_LEFT : PDM_CHANNEL_RIGHT;

`ifdef PDM2PCM_STEREO_EN
  assign take = 1'b1;
`else
  assign take = (edge_ch == channel_sel_i);
`endif

  pdm_clock_divider #(
    .MIN_DIV (SYNC_STAGES)
  ) u_div (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .active   (active),
    .load     (load),
    .divisor  (clock_divisor_i),
    .pdm_clk  (pdm_clk_o),
    .toggle_c (toggle_c),
    .rising_c (rising_c)
  );

  // Mic data synchronizer, free-running regardless of enable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pdm_data_i};
  end

  // The rising edge after WAKEUP_PERIODS counted ones closes the wake-up window,
  // so the first RUN sample is the falling edge that follows it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= MIC_IDLE;
      wake_q  <= '0;
      out_q   <= '0;
    end else begin
      out_q.valid <= 1'b0;
      if (!clk_en_i) begin
        state_q <= MIC_IDLE;
        wake_q  <= '0;
      end else begin
        case (state_q)
          MIC_IDLE: begin
            state_q <= MIC_WAKEUP;
            wake_q  <= '0;
          end
          MIC_WAKEUP: begin
            if (rising_c) begin
              if (wake_q == WAKE_W'(WAKEUP_PERIODS)) state_q <= MIC_RUN;
              else                                   wake_q  <= wake_q + WAKE_W'(1);
            end
          end
          MIC_RUN: begin
            if (toggle_c && take)
              out_q <= '{pdm: data_sync, valid: 1'b1, channel: edge_ch};
          end
          default: state_q <= MIC_IDLE;
        endcase
      end
    end
  end

  assign pdm_o     = out_q.pdm;
  assign valid_o   = out_q.valid;
  assign channel_o = out_q.channel;

endmodule

// File: tb/tb_pdm2pcm_mic_interface.sv
// Self-checking bench for pdm2pcm_mic_interface: vector table plus hand-written corner sequences.
module tb_pdm2pcm_mic_interface;

`ifdef PDM2PCM_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif
  localparam int WP = 16;
  localparam int FIRST_FALL = 2 * WP + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic [7:0] div = 8'd4;
  logic       sel = 1'b0;
  logic       inv = 1'b0;
  logic       pdm_data = 1'b0;
  logic       pdm_clk_o, pdm_o, valid_o, channel_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int cyc; bit pdm; bit ch; } exp_t;
  exp_t exp_q[$];

  typedef struct { int div; bit sel; bit inv; int exp_d; int nval; } vec_t;
  vec_t vecs[5];

  pdm2pcm_mic_interface dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .clk_en_i        (clk_en),
    .clock_divisor_i (div),
    .channel_sel_i   (sel),
    .pdm_clk_o       (pdm_clk_o),
    .pdm_data_i      (pdm_data),
    .pdm_o           (pdm_o),
    .valid_o         (valid_o),
    .channel_o       (channel_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data line: level equals the mic clock (optionally inverted), i.e. 1 before falling edges.
  initial forever begin
    @(negedge clk);
    pdm_data = pdm_clk_o ^ inv;
  end

  // Scoreboard: every valid_o must match the oldest expected sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid cyc=%0d got pdm=%0b ch=%0b, required no valid", cyc, pdm_o, channel_o);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || pdm_o != e.pdm || channel_o != e.ch) begin
            errors++;
            $display("FAIL sample got cyc=%0d pdm=%0b ch=%0b, required cyc=%0d pdm=%0b ch=%0b",
                     cyc, pdm_o, channel_o, e.cyc, e.pdm, e.ch);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  function automatic bit edge_taken(input int e, input bit s);
    return STEREO || ((e % 2 == 0) ? (s == 1'b0) : (s == 1'b1));
  endfunction

  // Edge j (1 = first rising) becomes visible n0 + j*(d+1); even edges are falling = left.
  task automatic push_run(input int n0, input int d, input bit s, input bit iv,
                          input int count, output int last_edge);
    int e = FIRST_FALL;
    int n = 0;
    last_edge = e;
    while (n < count) begin
      if (edge_taken(e, s)) begin
        exp_q.push_back('{n0 + e * (d + 1), ((e % 2) == 0) ^ iv, (e % 2) != 0});
        last_edge = e;
        n++;
      end
      e++;
    end
  endtask

  task automatic enable(output int n0);
    @(negedge clk);
    clk_en = 1'b1;
    n0 = cyc + 1;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic disable_if();
    @(negedge clk);
    clk_en = 1'b0;
    @(negedge clk);
    #1;
    check("clk_low_after_disable", int'(pdm_clk_o), 0);
  endtask

  initial begin
    int n0, last, rise, base, t;
    bit stuck;

    vecs[0] = '{4,   1'b0, 1'b0, 4, 3};
    vecs[1] = '{4,   1'b1, 1'b1, 4, 3};
    vecs[2] = '{0,   1'b0, 1'b0, 2, 2};
    vecs[3] = '{9,   1'b1, 1'b0, 9, 2};
    vecs[4] = '{1,   1'b1, 1'b1, 2, 2};

    #23;
    check("reset_pdm_clk", int'(pdm_clk_o), 0);
    check("reset_pdm", int'(pdm_o), 0);
    check("reset_valid", int'(valid_o), 0);
    check("reset_channel", int'(channel_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      div = 8'(vecs[i].div);
      sel = vecs[i].sel;
      inv = vecs[i].inv;
      enable(n0);
      push_run(n0, vecs[i].exp_d, vecs[i].sel, vecs[i].inv, vecs[i].nval, last);
      drain("vector", (last + 4) * (vecs[i].exp_d + 1));
      disable_if();
    end

    // Clamped divisor, then a mid-run change to 9.
    div = 8'd0; sel = 1'b0; inv = 1'b0;
    enable(n0);
    push_run(n0, 2, 1'b0, 1'b0, 3, last);
    drain("clamp", (last + 4) * 3);
    base = n0 + last * 3;
    div = 8'd9;
    for (int e = last + 1; e <= last + 4; e++) begin
      t = base + 3 + 10 * (e - last - 1);
      if (edge_taken(e, 1'b0)) exp_q.push_back('{t, (e % 2) == 0, (e % 2) != 0});
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("half_period_kept_low", int'(pdm_clk_o), 0);
    @(negedge clk); #1;
    check("half_period_ends_at_3", int'(pdm_clk_o), 1);
    drain("div_change", 60);
    disable_if();
    div = 8'd4;

    // Disable in a rising-edge toggle cycle during RUN, then full re-wake-up.
    sel = 1'b1; inv = 1'b0;
    enable(n0);
    push_run(n0, 4, 1'b1, 1'b0, 1, last);
    drain("pre_drop", (last + 4) * 5);
    rise = (last % 2 == 1) ? last + 2 : last + 1;
    for (int i = 0; i < 100 && cyc < n0 + rise * 5 - 1; i++) @(negedge clk);
    clk_en = 1'b0;
    @(negedge clk); #1;
    check("drop_valid", int'(valid_o), 0);
    check("drop_clk_low", int'(pdm_clk_o), 0);
    stuck = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (pdm_clk_o) stuck = 1'b1;
    end
    check("idle_clk_stays_low", int'(stuck), 0);
    enable(n0);
    push_run(n0, 4, 1'b1, 1'b0, 1, last);
    drain("re_enable", (last + 4) * 5);
    disable_if();

    // Asynchronous reset mid-RUN, then restart with enable held high.
    sel = 1'b1; inv = 1'b1;
    enable(n0);
    push_run(n0, 4, 1'b1, 1'b1, 1, last);
    drain("pre_reset", (last + 4) * 5);
    #1 rst_n = 1'b0;
    #1;
    check("async_pdm_clk", int'(pdm_clk_o), 0);
    check("async_pdm", int'(pdm_o), 0);
    check("async_valid", int'(valid_o), 0);
    check("async_channel", int'(channel_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = cyc + 1;
    push_run(n0, 4, 1'b1, 1'b1, 1, last);
    drain("post_reset", (last + 4) * 5);
    disable_if();

`ifndef PDM2PCM_STEREO_EN
    // Mono channel switch left->right mid-run.
    sel = 1'b0; inv = 1'b0;
    enable(n0);
    exp_q.push_back('{n0 + 34 * 5, 1'b1, 1'b0});
    exp_q.push_back('{n0 + 36 * 5, 1'b1, 1'b0});
    exp_q.push_back('{n0 + 37 * 5, 1'b0, 1'b1});
    exp_q.push_back('{n0 + 39 * 5, 1'b0, 1'b1});
    for (int i = 0; i < 400 && exp_q.size() > 2; i++) begin
      @(negedge clk); #1;
    end
    sel = 1'b1;
    drain("channel_switch", 60);
    disable_if();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
